// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master with per-transfer
// CPOL/CPHA and SCLK divider, start/busy/done handshake toward the host.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN adds the lsb_first input
// (latched at start) for LSB-first transmit and receive.
module spi_master_param #(
    parameter int DATA_W   = 8,
    parameter int NUM_CS   = 2,
    parameter int DIV_W    = 8,
    parameter int CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic [DATA_W-1:0]   tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    output logic [DATA_W-1:0]   rx_data,
    output logic                busy,
    output logic                done,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [NUM_CS-1:0]   spi_cs_n
);

    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE   = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] PENULT_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [EDGE_W-1:0] r_edge;
    logic              r_cpha;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_done;
    logic [NUM_CS-1:0] r_cs_n;

    logic [NUM_CS-1:0] w_cs_n_sel;
    logic              w_accept;
    logic              w_tick;
    logic              w_edge;
    logic              w_finish;
    logic              w_leading;
    logic              w_shift;
    logic              w_sample;
    logic              w_lsb;
    logic              w_lsb_in;
    logic              w_tx_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic              r_lsb;

    assign w_lsb_in = lsb_first;
    assign w_lsb    = r_lsb;

    // Bit order is frozen for the whole transfer at start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lsb <= 1'b0;
        end else if (w_accept) begin
            r_lsb <= lsb_first;
        end
    end
`else
    assign w_lsb_in = 1'b0;
    assign w_lsb    = 1'b0;
`endif

    // r_edge counts edges already produced, so the upcoming edge number is
    // r_edge+1: odd (leading) exactly when r_edge is even.
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_tick    = (r_cnt == r_div);
    assign w_leading = ~r_edge[0];
    // With cpha=0 the final trailing edge has no further bit to present.
    assign w_shift   = w_edge & (r_cpha ? w_leading
                                        : (~w_leading & (r_edge != PENULT_EDGE)));
    assign w_sample  = w_edge & (r_cpha ? ~w_leading : w_leading);
    assign w_tx_bit  = w_lsb ? r_tx[0] : r_tx[DATA_W-1];

    // Decode the selected chip select; out-of-range indices select nothing
    always_comb begin
        w_cs_n_sel = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) begin
                w_cs_n_sel[i] = 1'b0;
            end
        end
    end

    // Phase sequencing: each half period lasts r_div+1 cycles (w_tick)
    always_comb begin
        w_state_nxt = r_state;
        w_edge      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_tick) begin
                    w_state_nxt = S_XFER;
                    w_edge      = 1'b1;
                end
            end
            S_XFER: begin
                if (w_tick) begin
                    if (r_edge == LAST_EDGE) begin
                        w_state_nxt = S_TRAIL;
                    end else begin
                        w_edge = 1'b1;
                    end
                end
            end
            S_TRAIL: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Half-period counter, edge counter and latched transfer settings
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_edge <= '0;
            r_div  <= '0;
            r_cpha <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_edge <= '0;
            r_div  <= clk_div;
            r_cpha <= cpha;
        end else if (r_state != S_IDLE) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_edge) begin
                r_edge <= r_edge + 1'b1;
            end
        end
    end

    // Transmit and receive shift registers; with cpha=0 the first bit is
    // already on MOSI at start, so the register is preloaded one bit ahead.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (cpha) begin
                r_tx <= tx_data;
            end else begin
                r_tx <= w_lsb_in ? (tx_data >> 1) : (tx_data << 1);
            end
        end else if (w_shift) begin
            r_tx <= w_lsb ? (r_tx >> 1) : (r_tx << 1);
        end
        if (w_sample) begin
            r_rx <= w_lsb ? {spi_miso, r_rx[DATA_W-1:1]}
                          : {r_rx[DATA_W-2:0], spi_miso};
        end
    end

    // Registered SPI pins, received word and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
            r_cs_n    <= '1;
            r_rx_data <= '0;
        end else begin
            r_done <= w_finish;
            if (r_state == S_IDLE) begin
                r_sclk <= cpol;
            end else if (w_edge) begin
                r_sclk <= ~r_sclk;
            end
            if (w_accept) begin
                r_cs_n <= w_cs_n_sel;
                if (!cpha) begin
                    r_mosi <= w_lsb_in ? tx_data[0] : tx_data[DATA_W-1];
                end
            end else if (w_shift) begin
                r_mosi <= w_tx_bit;
            end
            if (w_finish) begin
                r_cs_n    <= '1;
                r_rx_data <= r_rx;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign rx_data  = r_rx_data;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: a behavioural SPI slave drives MISO
// and captures MOSI; expectations are queued at start and checked at done.
module tb_spi_master_param;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cpol;
    logic       cpha;
    logic [7:0] clk_div;
    logic [1:0] cs_sel;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [1:0] spi_cs_n;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic       lsb_first;
`endif

    logic       loop_en;
    logic       s_miso;
    assign spi_miso = loop_en ? spi_mosi : s_miso;

    spi_master_param #(
        .DATA_W   (8),
        .NUM_CS   (2),
        .DIV_W    (8),
        .CS_SEL_W (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
        .cs_sel   (cs_sel),
        .tx_data  (tx_data),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0]  rx;
        int unsigned done_cyc;
        logic [1:0]  cs;
        logic [7:0]  mosi;
        bit          chk_fall;
    } exp_t;
    exp_t q[$];

    // settings of the transfer being launched, read by the slave at busy rise
    bit         cur_cpol, cur_cpha;
    int         cur_h;
    logic [7:0] cur_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // ---------------- behavioural SPI slave / bus observer ----------------
    bit         s_cpol, s_cpha;
    int         s_h, s_ptr, s_edges, s_bad_sp, s_bad_fall, s_cs_bad;
    int unsigned s_rise;
    logic [7:0] s_word, s_cap;
    logic [1:0] s_cs;
    logic       p_busy = 1'b0, p_sclk = 1'b0, p_mosi = 1'b0;

    always @(negedge clk) begin
        if (busy && !p_busy) begin
            s_cpol = cur_cpol; s_cpha = cur_cpha; s_h = cur_h; s_word = cur_word;
            s_ptr = 0; s_edges = 0; s_bad_sp = 0; s_bad_fall = 0; s_cs_bad = 0;
            s_cap = 8'h00; s_rise = cyc; s_cs = spi_cs_n;
            if (!s_cpha) s_miso = s_word[7];
        end else if (busy) begin
            if (spi_cs_n != s_cs) s_cs_bad++;
            if (spi_mosi != p_mosi && !(p_sclk && !spi_sclk)) s_bad_fall++;
            if (spi_sclk != p_sclk) begin
                s_edges++;
                if (cyc != s_rise + s_edges * s_h) s_bad_sp++;
                if (p_sclk == s_cpol) begin
                    if (!s_cpha) s_cap = {s_cap[6:0], spi_mosi};
                    else begin
                        s_miso = s_word[7-s_ptr];
                        s_ptr++;
                    end
                end else begin
                    if (!s_cpha) begin
                        s_ptr++;
                        if (s_ptr < 8) s_miso = s_word[7-s_ptr];
                    end else s_cap = {s_cap[6:0], spi_mosi};
                end
            end
        end
        p_busy = busy; p_sclk = spi_sclk; p_mosi = spi_mosi;
    end

    // ---------------- monitor: pop and compare on every done ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 required no pulse (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("rx_data", rx_data, e.rx);
                chk("done_cycle", cyc, e.done_cyc);
                chk("busy_at_done", busy, 1'b0);
                chk("cs_release", spi_cs_n, 2'b11);
                chk("cs_during", s_cs, e.cs);
                chk("cs_stable", s_cs_bad, 0);
                chk("edge_count", s_edges, 16);
                chk("edge_timing", s_bad_sp, 0);
                chk("mosi_stream", s_cap, e.mosi);
                if (e.chk_fall) chk("mosi_on_fall_only", s_bad_fall, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic start_xfer(input bit pol, input bit pha, input int div, input int cs,
                              input logic [7:0] tx, input logic [7:0] word,
                              input bit loop, input bit lsb, input bit chk_fall);
        exp_t e;
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL start_timeout: got busy=1 required 0");
        end
        cpol = pol; cpha = pha; clk_div = 8'(div); cs_sel = 2'(cs); tx_data = tx;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        loop_en = loop;
        cur_cpol = pol; cur_cpha = pha; cur_h = div + 1; cur_word = word;
        e.rx       = loop ? tx : (lsb ? rev8(word) : word);
        e.done_cyc = cyc + 1 + (div + 1) * (2 * 8 + 2);
        e.cs       = 2'b11;
        if (cs < 2) e.cs[cs] = 1'b0;
        e.mosi     = lsb ? rev8(tx) : tx;
        e.chk_fall = chk_fall;
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got %0d pending required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        int dc;
        rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
        cs_sel = 2'd0; tx_data = 8'h00; loop_en = 1'b0; s_miso = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_cs_n", spi_cs_n, 2'b11);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // mode 0, div 1, loopback 0xA5
        chk("idle_sclk_mode0", spi_sclk, 1'b0);
        start_xfer(0, 0, 1, 0, 8'hA5, 8'h00, 1, 0, 0);
        wait_idle();

        // mode 3, div 0, MISO held high
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_sclk_mode3_before", spi_sclk, 1'b1);
        start_xfer(1, 1, 0, 0, 8'h3C, 8'hFF, 0, 0, 1);
        wait_idle();
        @(negedge clk);
        chk("idle_sclk_mode3_after", spi_sclk, 1'b1);

        // modes 1 and 2 against a slave returning 0x5A
        start_xfer(0, 1, 2, 0, 8'hC3, 8'h5A, 0, 0, 0);
        wait_idle();
        start_xfer(1, 0, 1, 0, 8'hC3, 8'h5A, 0, 0, 0);
        wait_idle();

        // chip-select routing, including an out-of-range index
        start_xfer(0, 0, 0, 1, 8'h96, 8'h69, 0, 0, 0);
        wait_idle();
        start_xfer(0, 0, 0, 2, 8'h12, 8'hE7, 0, 0, 0);
        wait_idle();

        // ignored start while busy, then back-to-back start on the done cycle
        start_xfer(0, 0, 1, 0, 8'h5C, 8'hB4, 0, 0, 0);
        repeat (6) @(negedge clk);
        tx_data = 8'hFF; cpha = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", done, 1'b1);
        start_xfer(1, 1, 0, 1, 8'h81, 8'h24, 0, 0, 1);
        chk("b2b_busy_next", busy, 1'b1);
        wait_idle();
        chk("done_count_b2b", done_cnt, 8);

        // reset on edge 5 of a transfer
        start_xfer(0, 0, 3, 0, 8'hF0, 8'h0F, 0, 0, 0);
        n = 0;
        while (s_edges < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        q.delete();
        #1;
        chk("abort_cs_n", spi_cs_n, 2'b11);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx", rx_data, 8'h00);
        chk("abort_sclk", spi_sclk, 1'b0);
        chk("abort_done", done, 1'b0);
        dc = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_no_done", done_cnt, dc);

`ifdef SPI_MASTER_LSB_FIRST_EN
        // LSB-first loopback of 0x01: first MOSI bit is 1
        start_xfer(0, 0, 1, 0, 8'h01, 8'h00, 1, 1, 0);
        wait_idle();
        chk("lsb_first_bit", s_cap[7], 1'b1);
        start_xfer(1, 1, 0, 1, 8'hB2, 8'h00, 1, 1, 1);
        wait_idle();
`endif

        // randomized transfers, back-to-back or with idle gaps
        for (int t = 0; t < 24; t++) begin
            bit          pol, pha, loop;
            int          div, cs;
            logic [7:0]  tx, word;
            pol  = 1'($urandom_range(0, 1));
            pha  = 1'($urandom_range(0, 1));
            loop = 1'($urandom_range(0, 1));
            div  = $urandom_range(0, 3);
            cs   = $urandom_range(0, 3);
            tx   = 8'($urandom);
            word = 8'($urandom);
            start_xfer(pol, pha, div, cs, tx, word, loop, 0, pol & pha);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
